spectrum_report_builder: RTL
============================

Name: spectrum_report_builder

Overview:
- Terminal consumer of the detector output stream: the receiving end of det_valid/det_ready/det_last/det_data.
- Accepts one frame of per-bin detection words and accumulates occupancy and peak statistics.
- After each frame, emits a fixed 4-beat report packet on a valid/ready/last stream toward the host/DMA side.
- Backpressures the detector only while a report is being emitted.

Parameters:
- FFT_MAX_LOG2, 12, width of cfg_fft_log2; maximum frame is 2**FFT_MAX_LOG2 bins.
- CNT_W, 16, width of bin, occupancy, frame and peak-index counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_fft_log2  in  FFT_MAX_LOG2  expected frame size log2; sampled on first beat of each frame.
- s_valid  in  1  detection beat valid; connects to det_valid.
- s_ready  out  1  ready to detector; connects to det_ready.
- s_last  in  1  final bin of frame.
- s_data  in  32  bit31 = over-threshold flag; [30:0] = unsigned magnitude.
- m_valid  out  1  report beat valid.
- m_ready  in  1  report beat accepted.
- m_last  out  1  asserted on report beat 3 only.
- m_data  out  32  report beat.

Behaviour:
- Reset (rst=1 at posedge): state=ACCUM; s_ready=0 during reset, 1 the cycle after; m_valid=0, m_last=0, m_data=0; all counters, peak registers and frame_cnt cleared. Reset mid-frame or mid-report discards all partial data; no report is emitted.
- FSM has two states: ACCUM and EMIT. The beat index 0..3 is held in a 2-bit counter.
- ACCUM:
  - s_ready=1, m_valid=0.
  - Each beat accepted (s_valid&&s_ready): bin_cnt++; occ_cnt++ if s_data[31].
  - If s_data[30:0] > peak_mag (strict), then peak_mag <= s_data[30:0] and peak_idx <= bin_cnt before increment. Ties keep the lowest index. The first beat of a frame always loads the peak.
  - Counters saturate at all-ones and do not wrap.
  - Accepting the beat with s_last=1 goes to EMIT next cycle, with final stats latched into report registers that include this beat.
- EMIT:
  - s_ready=0. m_valid=1 from the first cycle after the last beat is accepted (latency 1).
  - m_data and m_last are held stable while m_valid && !m_ready.
  - Beat index advances on each m_valid&&m_ready.
  - Accepting beat 3 returns to ACCUM next cycle, clears accumulators, and increments frame_cnt (wraps modulo 2**CNT_W).
- Report format:
  - beat0 = {frame_cnt[15:0], bin_cnt[15:0]}
  - beat1 = {err, 15'b0, occ_cnt[15:0]}
  - beat2 = {16'b0, peak_idx[15:0]}
  - beat3 = {1'b0, peak_mag[30:0]}, m_last=1
- Boundary cases:
  - A single-beat frame (s_last on the first beat) gives bin_cnt=1 and peak_idx=0.
  - s_valid=0 gaps inside a frame are ignored.
  - s_last while in EMIT cannot be accepted because s_ready=0.
  - m_ready held high gives 4 consecutive beats; ACCUM resumes on cycle 5 after the last input beat.
  - Minimum frame turnaround is the frame length plus 4 cycles.

Optional Feature:
- Macro SPEC_RPT_LEN_CHECK_EN.
- Defined: on the first beat, expected_len = 1<<cfg_fft_log2 is latched. err=1 in beat1 if the final bin_cnt != expected_len, which includes saturation.
- Not defined: err is constant 0 and no length logic is synthesized.

Decomposition:
- Package spectrum_report_pkg holds:
  - RPT_BEATS=4;
  - DET_FLAG_BIT=31;
  - DET_MAG_W=31;
  - state enum {ACCUM, EMIT};
  - beat-field offsets;
  - a function building each beat word from the stats struct;
  - the stats struct typedef {frame_cnt, bin_cnt, occ_cnt, peak_idx, peak_mag, err}.
- One natural sub-module, spectrum_peak_tracker: running strict-max with index, with a clear input and first-beat load.

Test Plan:
- 8-beat frame with flags on bins 2,5; magnitudes 10,40,40,7,3,99,1,0 and m_ready=1 -> beats 0x00000008, 0x00000002, 0x00000005, 0x00000063; m_last on beat3 only; s_ready low exactly 4 cycles.
- Tie: magnitudes 50,50,20,50 -> peak_idx=0, peak_mag=50.
- m_ready held low 10 cycles during beat1 -> m_data/m_last stable, s_ready stays 0, no beat lost; next frame report shows frame_cnt=1.
- Assert rst mid-frame after 3 beats, then send 4-beat frame -> single report with frame_cnt=0, bin_cnt=4.
- With SPEC_RPT_LEN_CHECK_EN, cfg_fft_log2=3, 6-beat frame -> beat1 bit31=1; an 8-beat frame gives bit31=0. Without the macro, bit31=0 in both cases.
- 65536 frames back-to-back -> frame_cnt wraps to 0x0000 after 0xFFFF; single-beat frame yields bin_cnt=1, peak_idx=0.

Source files
------------

// File: rtl/spectrum_report_pkg.sv
// Shared types and the report-beat packer for spectrum_report_builder.
package spectrum_report_pkg;
  localparam int RPT_BEATS    = 4;
  localparam int DET_FLAG_BIT = 31;
  localparam int DET_MAG_W    = 31;
  localparam int STAT_W       = 16;

  // Bit offsets of each field inside its report beat
  localparam int FRAME_LSB = 16;
  localparam int BIN_LSB   = 0;
  localparam int ERR_BIT   = 31;
  localparam int OCC_LSB   = 0;
  localparam int PIDX_LSB  = 0;
  localparam int PMAG_LSB  = 0;

  typedef enum logic {ACCUM, EMIT} state_t;

  typedef struct packed {
    logic [STAT_W-1:0]    frame_cnt;
    logic [STAT_W-1:0]    bin_cnt;
    logic [STAT_W-1:0]    occ_cnt;
    logic [STAT_W-1:0]    peak_idx;
    logic [DET_MAG_W-1:0] peak_mag;
    logic                 err;
  } stats_t;

  function automatic logic [31:0] build_beat(input stats_t s, input logic [1:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      2'd0: begin
        w[FRAME_LSB +: STAT_W] = s.frame_cnt;
        w[BIN_LSB   +: STAT_W] = s.bin_cnt;
      end
      2'd1: begin
        w[ERR_BIT]            = s.err;
        w[OCC_LSB +: STAT_W]  = s.occ_cnt;
      end
      2'd2:    w[PIDX_LSB +: STAT_W]    = s.peak_idx;
      default: w[PMAG_LSB +: DET_MAG_W] = s.peak_mag;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/spectrum_report_builder_if.sv
// Detector input stream and report output stream of spectrum_report_builder.
interface spectrum_report_builder_if;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [31:0] m_data;

  modport slave  (input  s_valid, s_last, s_data, m_ready,
                  output s_ready, m_valid, m_last, m_data);
  modport master (output s_valid, s_last, s_data, m_ready,
                  input  s_ready, m_valid, m_last, m_data);
endinterface

// File: rtl/spectrum_peak_tracker.sv
// Running strict maximum of magnitude with the index where it first occurred.
module spectrum_peak_tracker #(
  parameter int MAG_W = 31,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             first,
  input  logic [MAG_W-1:0] mag,
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] peak_mag,
  output logic [IDX_W-1:0] peak_idx
);
  // Strict compare keeps the earliest index on ties
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak_mag <= '0;
      peak_idx <= '0;
    end else if (en && (first || mag > peak_mag)) begin
      peak_mag <= mag;
      peak_idx <= idx;
    end
  end
endmodule

// File: rtl/spectrum_report_builder.sv
// Per-frame occupancy/peak statistics, emitted as a 4-beat report.
// Optional frame-length check enabled by SPEC_RPT_LEN_CHECK_EN.
module spectrum_report_builder
  import spectrum_report_pkg::*;
#(
  parameter int FFT_MAX_LOG2 = 12,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FFT_MAX_LOG2-1:0] cfg_fft_log2,
  spectrum_report_builder_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [1:0]           beat_q;
  logic [CNT_W-1:0]     bin_cnt, occ_cnt, frame_cnt, peak_idx;
  logic [DET_MAG_W-1:0] peak_mag;
  logic                 s_acc, m_acc, first_beat, rpt_done, err;
  stats_t               stats;

  assign s_acc      = bus.s_valid && bus.s_ready;
  assign m_acc      = bus.m_valid && bus.m_ready;
  assign first_beat = (bin_cnt == '0);
  assign rpt_done   = m_acc && (beat_q == 2'(RPT_BEATS-1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = '0;
    if (!rst) begin
      case (state_q)
        ACCUM: begin
          bus.s_ready = 1'b1;
          if (s_acc && bus.s_last) state_d = EMIT;
        end
        EMIT: begin
          bus.m_valid = 1'b1;
          bus.m_data  = build_beat(stats, beat_q);
          bus.m_last  = (beat_q == 2'(RPT_BEATS-1));
          if (rpt_done) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Accumulators are frozen during EMIT, so they double as the report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt   <= '0;
      occ_cnt   <= '0;
      frame_cnt <= '0;
      beat_q    <= '0;
    end else begin
      if (s_acc) begin
        if (bin_cnt != CNT_MAX) bin_cnt <= bin_cnt + 1'b1;
        if (bus.s_data[DET_FLAG_BIT] && occ_cnt != CNT_MAX) occ_cnt <= occ_cnt + 1'b1;
      end
      if (m_acc) beat_q <= beat_q + 2'd1;
      if (rpt_done) begin
        bin_cnt   <= '0;
        occ_cnt   <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  spectrum_peak_tracker #(.MAG_W(DET_MAG_W), .IDX_W(CNT_W)) u_peak (
    .clk      (clk),
    .rst      (rst),
    .clear    (rpt_done),
    .en       (s_acc),
    .first    (first_beat),
    .mag      (bus.s_data[DET_MAG_W-1:0]),
    .idx      (bin_cnt),
    .peak_mag (peak_mag),
    .peak_idx (peak_idx)
  );

`ifdef SPEC_RPT_LEN_CHECK_EN
  // A shift of 32 or more yields 0, which never matches a non-empty frame
  logic [31:0] exp_len;
  always_ff @(posedge clk) begin
    if (rst)                      exp_len <= '0;
    else if (s_acc && first_beat) exp_len <= 32'd1 << cfg_fft_log2;
  end
  assign err = (32'(bin_cnt) != exp_len);
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_fft_log2;
  assign err        = 1'b0;
`endif

  always_comb begin
    stats           = '0;
    stats.frame_cnt = STAT_W'(frame_cnt);
    stats.bin_cnt   = STAT_W'(bin_cnt);
    stats.occ_cnt   = STAT_W'(occ_cnt);
    stats.peak_idx  = STAT_W'(peak_idx);
    stats.peak_mag  = peak_mag;
    stats.err       = err;
  end
endmodule
